// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave holding NREGS read/write control registers with byte strobes,
// DECERR on unmapped words and a one-cycle write strobe per register.
module axi4l_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [ADDR_WIDTH-1:0]         araddr,
  input  logic [2:0]                    arprot,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic [NREGS*DATA_WIDTH-1:0]   regs_o,
  output logic [NREGS-1:0]              wr_stb_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                    aw_set;
  logic                    w_set;
  logic                    ar_set;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic                    wr_req;
  logic                    wr_req_d0;
  logic [ADDR_WIDTH-1:0]   wr_addr_d0;
  logic [DATA_WIDTH-1:0]   wr_data_d0;
  logic [STRB_WIDTH-1:0]   wr_strb_d0;
  logic [31:0]             wr_idx;
  logic                    wr_hit;
  logic [NREGS-1:0]        wr_sel;
  logic                    wr_ack;
  logic [1:0]              wr_ack_resp;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [31:0]             rd_idx;
  logic                    rd_hit;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_req;
  logic                    rd_ack;
  logic [DATA_WIDTH-1:0]   rd_ack_data;
  logic [1:0]              rd_ack_resp;
  logic [DATA_WIDTH-1:0]   regs [NREGS];
  logic                    unused_bits;

  assign awready = ~aw_set;
  assign wready  = ~w_set;
  assign arready = ~ar_set;
  assign aw_hs   = awvalid & ~aw_set;
  assign w_hs    = wvalid & ~w_set;
  assign ar_hs   = arvalid & ~ar_set;

  assign unused_bits = ^{awprot, arprot, wr_addr_d0[ADDR_LSB-1:0], ar_addr_q[ADDR_LSB-1:0]};

  // Each channel latches its payload at its own handshake and stays blocked
  // until B completes; wr_req fires once, when the pair first becomes complete.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_set    <= 1'b0;
      w_set     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wr_req    <= 1'b0;
    end else begin
      wr_req <= (aw_set | aw_hs) & (w_set | w_hs) & ~(aw_set & w_set);
      if (aw_hs) begin
        aw_set    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_set    <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (bvalid && bready) begin
        aw_set <= 1'b0;
        w_set  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_req_d0  <= 1'b0;
      wr_addr_d0 <= '0;
      wr_data_d0 <= '0;
      wr_strb_d0 <= '0;
    end else begin
      wr_req_d0  <= wr_req;
      wr_addr_d0 <= aw_addr_q;
      wr_data_d0 <= w_data_q;
      wr_strb_d0 <= w_strb_q;
    end
  end

  assign wr_idx = 32'(wr_addr_d0[ADDR_WIDTH-1:ADDR_LSB]);
  assign wr_hit = (wr_idx < 32'(NREGS));

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (wr_req_d0 && wr_hit && (wr_idx == 32'(k))) begin
        wr_sel[k] = 1'b1;
      end
    end
  end

  // The strobe is registered alongside the update so both show in the same cycle,
  // and it fires even when no byte lane is enabled.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
      wr_stb_o <= '0;
    end else begin
      wr_stb_o <= wr_sel;
      for (int k = 0; k < NREGS; k++) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wr_sel[k] && wr_strb_d0[b]) begin
            regs[k][8*b +: 8] <= wr_data_d0[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ack      <= 1'b0;
      wr_ack_resp <= RESP_OKAY;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
    end else begin
      wr_ack <= wr_req_d0;
      if (wr_req_d0) begin
        wr_ack_resp <= wr_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (wr_ack) begin
        bvalid <= 1'b1;
        bresp  <= wr_ack_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_regs_out
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_set    <= 1'b0;
      ar_addr_q <= '0;
      rd_req    <= 1'b0;
    end else begin
      rd_req <= ar_hs;
      if (ar_hs) begin
        ar_set    <= 1'b1;
        ar_addr_q <= araddr;
      end
      if (rvalid && rready) begin
        ar_set <= 1'b0;
      end
    end
  end

  assign rd_idx = 32'(ar_addr_q[ADDR_WIDTH-1:ADDR_LSB]);
  assign rd_hit = (rd_idx < 32'(NREGS));

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (rd_idx == 32'(k)) begin
        rd_word = regs[k];
      end
    end
  end

  // Read data is sampled from the registers before any same-edge write lands.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ack      <= 1'b0;
      rd_ack_data <= '0;
      rd_ack_resp <= RESP_OKAY;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= RESP_OKAY;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_ack_data <= rd_hit ? rd_word : '0;
        rd_ack_resp <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (rd_ack) begin
        rvalid <= 1'b1;
        rdata  <= rd_ack_data;
        rresp  <= rd_ack_resp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Bench for axi4l_regbank: table of write/read vectors plus hand-built
// corner sequences; B/R responses are scoreboarded through queues.
module tb_axi4l_regbank;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int NV = 17;

  logic              aclk = 1'b0;
  logic              areset;
  logic              awvalid, awready;
  logic [AW-1:0]     awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic [NR*DW-1:0]  regs_o;
  logic [NR-1:0]     wr_stb_o;

  axi4l_regbank #(.DATA_WIDTH(DW), .NREGS(NR), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit            isWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [DW-1:0] expData;
    logic [1:0]    expResp;
    logic [NR-1:0] expStb;
  } vec_t;

  vec_t          vecs [NV];
  logic [1:0]    bq [$];
  logic [DW+1:0] rq [$];
  logic [DW+1:0] rexp;
  logic [DW-1:0] modelRegs [NR];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [NR*DW-1:0] packModel();
    logic [NR*DW-1:0] p;
    for (int k = 0; k < NR; k++) p[k*DW +: DW] = modelRegs[k];
    return p;
  endfunction

  // Scoreboard: responses are popped at the handshake, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!areset && bvalid && bready) begin
      checkOutput("B response expected", 128'(bq.size() > 0), 128'(1));
      if (bq.size() > 0) checkOutput("bresp", bresp, bq.pop_front());
    end
    if (!areset && rvalid && rready) begin
      checkOutput("R response expected", 128'(rq.size() > 0), 128'(1));
      if (rq.size() > 0) begin
        rexp = rq.pop_front();
        checkOutput("rdata", rdata, rexp[DW+1:2]);
        checkOutput("rresp", rresp, rexp[1:0]);
      end
    end
  end

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] strb, input logic [DW-1:0] expReg,
                         input logic [1:0] expResp, input logic [NR-1:0] expStb);
    int cnt;
    int stbCycles;
    int stbAt;
    logic [NR-1:0] stbSeen;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(expResp);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    cnt = 0; stbCycles = 0; stbAt = -1; stbSeen = '0;
    while (!bvalid && cnt < 20) begin
      if (wr_stb_o != '0) begin stbSeen |= wr_stb_o; stbCycles++; stbAt = cnt; end
      @(posedge aclk); #1;
      cnt++;
    end
    if (wr_stb_o != '0) begin stbSeen |= wr_stb_o; stbCycles++; stbAt = cnt; end
    checkOutput("bvalid latency", cnt, 3);
    checkOutput("wr_stb_o mask", stbSeen, expStb);
    if (expStb != '0) begin
      checkOutput("wr_stb_o cycles", stbCycles, 1);
      checkOutput("wr_stb_o timing", stbAt, 2);
      modelRegs[addr[AW-1:2]] = expReg;
    end else begin
      checkOutput("no strobe cycles", stbCycles, 0);
    end
    @(posedge aclk); #1;
    checkOutput("readys after B", {awready, wready, bvalid}, 3'b110);
    checkOutput("regs_o", regs_o, packModel());
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] expData,
                        input logic [1:0] expResp);
    int cnt;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    rq.push_back({expData, expResp});
    @(posedge aclk); #1;
    arvalid = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 20) begin
      @(posedge aclk); #1;
      cnt++;
    end
    checkOutput("rvalid latency", cnt, 2);
    @(posedge aclk); #1;
    checkOutput("arready after R", {arready, rvalid}, 2'b10);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) doWrite(v.addr, v.data, v.strb, v.expData, v.expResp, v.expStb);
    else           doRead(v.addr, v.expData, v.expResp);
  endtask

  initial begin
    logic sawStb;
    logic sawB;
    int   cnt;
    areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awprot = 3'b000; arprot = 3'b000;
    bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < NR; k++) modelRegs[k] = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    checkOutput("reset handshake state", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    checkOutput("reset regs_o", regs_o, '0);
    checkOutput("reset wr_stb_o", wr_stb_o, '0);
    checkOutput("reset rdata/resps", {rdata, rresp, bresp}, '0);

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00, 4'b0000};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h0,        2'b00, 4'b0000};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h0,        2'b00, 4'b0000};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,        2'b00, 4'b0000};
    vecs[4]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'b00, 4'b0100};
    vecs[5]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 4'b0000};
    vecs[6]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'hDE22BE44, 2'b00, 4'b0100};
    vecs[7]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDE22BE44, 2'b00, 4'b0000};
    vecs[8]  = '{1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 32'h0,        2'b11, 4'b0000};
    vecs[9]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0,        2'b11, 4'b0000};
    vecs[10] = '{1'b1, 8'h0D, 32'h12345678, 4'hC, 32'h12340000, 2'b00, 4'b1000};
    vecs[11] = '{1'b0, 8'h0F, 32'h0,        4'h0, 32'h12340000, 2'b00, 4'b0000};
    vecs[12] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 4'b0001};
    vecs[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00, 4'b0000};
    vecs[14] = '{1'b1, 8'h04, 32'h000000FF, 4'h1, 32'h000000FF, 2'b00, 4'b0010};
    vecs[15] = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h000000FF, 2'b00, 4'b0000};
    vecs[16] = '{1'b0, 8'hFC, 32'h0,        4'h0, 32'h0,        2'b11, 4'b0000};

    for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);

    // Read of register 2 decoding on the same edge that its write lands
    awaddr = 8'h08; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h08; arvalid = 1'b1;
    rq.push_back({32'hDE22BE44, 2'b00});
    @(posedge aclk); #1;
    arvalid = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    modelRegs[2] = 32'h0BADF00D;
    checkOutput("regs_o after overlap", regs_o, packModel());
    doRead(8'h08, 32'h0BADF00D, 2'b00);

    // W three cycles ahead of AW, then B stalled for five cycles
    wdata = 32'hA1B2C3D4; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    checkOutput("wready low after W only", {awready, wready}, 2'b10);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    awaddr = 8'h0C; awvalid = 1'b1; bready = 1'b0;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    checkOutput("both readys low", {awready, wready}, 2'b00);
    cnt = 0;
    while (!bvalid && cnt < 20) begin
      @(posedge aclk); #1;
      cnt++;
    end
    checkOutput("split bvalid latency", cnt, 3);
    sawB = 1'b1;
    sawStb = 1'b0;
    repeat (5) begin
      @(posedge aclk); #1;
      sawB &= bvalid;
      sawStb |= awready | wready;
    end
    checkOutput("bvalid held under backpressure", sawB, 1'b1);
    checkOutput("readys stay low under backpressure", sawStb, 1'b0);
    bready = 1'b1;
    @(posedge aclk); #1;
    checkOutput("readys rise after bready", {awready, wready, bvalid}, 3'b110);
    modelRegs[3] = 32'hA1B2C3D4;
    checkOutput("regs_o after split write", regs_o, packModel());

    // Reset one cycle after the handshake aborts the write to register 1
    awaddr = 8'h04; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("abort handshake taken", {awready, wready}, 2'b00);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    sawStb = 1'b0;
    sawB = 1'b0;
    repeat (6) begin
      sawStb |= |wr_stb_o;
      sawB |= bvalid;
      @(posedge aclk); #1;
    end
    checkOutput("no strobe after abort", sawStb, 1'b0);
    checkOutput("no bvalid after abort", sawB, 1'b0);
    for (int k = 0; k < NR; k++) modelRegs[k] = '0;
    checkOutput("regs_o after abort", regs_o, packModel());
    checkOutput("readys after abort", {awready, wready, arready}, 3'b111);

    repeat (3) @(posedge aclk);
    #1;
    checkOutput("scoreboard drained", bq.size() + rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
